// File: rtl/stream_buffer_fifo_pkg.sv
// Shared constants and sizing helper for the stream buffer FIFO.
package stream_buffer_fifo_pkg;

    localparam logic RESET_ACTIVE = 1'b0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    localparam int DEF_DEPTH = 4;
    localparam int PTR_W     = clog2(DEF_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

endpackage

// File: rtl/stream_buffer_fifo_ptr.sv
// Wrapping read/write pointer; wrap is implicit from the power-of-two range.
module buf_ptr_ctr
    import stream_buffer_fifo_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) ptr_d = ptr_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset == RESET_ACTIVE) ptr_q <= '0;
        else                       ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/stream_buffer_fifo.sv
// First-word-fall-through valid/ready FIFO with occupancy, almost-full and sticky overflow.
module stream_buffer_fifo
    import stream_buffer_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [WIDTH-1:0]        s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic [clog2(DEPTH):0]   count,
    output logic                    almost_full,
    output logic                    ovf_err
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_q, count_d;
    logic             af_q, af_d;
    logic             ovf_q, ovf_d;
    logic             full, push, pop;

    assign full    = (count_q == CW'(DEPTH));
    // s_ready looks only at registered count, so a pop never frees a slot in the same cycle
    assign s_ready = (reset != RESET_ACTIVE) && !full;
    assign m_valid = (count_q != '0);
    assign m_data  = mem[rd_ptr];
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    buf_ptr_ctr #(.W(PW)) u_wr_ptr (.clk(clk), .reset(reset), .inc_i(push), .ptr_o(wr_ptr));
    buf_ptr_ctr #(.W(PW)) u_rd_ptr (.clk(clk), .reset(reset), .inc_i(pop),  .ptr_o(rd_ptr));

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        af_d  = (count_d >= CW'(AF_LEVEL));
        ovf_d = ovf_q | (s_valid & full);
    end

    always_ff @(posedge clk) begin
        if (reset == RESET_ACTIVE) begin
            count_q <= '0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    assign count       = count_q;
    assign almost_full = af_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_stream_buffer_fifo.sv
// Directed plan plus random traffic, checked against a queue-based model.
module tb_stream_buffer_fifo;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 4;
    localparam int AF_LEVEL = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [2:0]       count;
    logic             almost_full;
    logic             ovf_err;

    stream_buffer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .almost_full(almost_full), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [WIDTH-1:0] q[$];
    logic             m_ovf;
    logic             known;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One clock cycle: drive, check visible outputs, then advance the model on the edge.
    task automatic cyc(input logic rst, input logic sv, input logic [WIDTH-1:0] sd, input logic mr);
        bit push, pop;
        reset = rst; s_valid = sv; s_data = sd; m_ready = mr;
        #1;
        chk("s_ready", 32'(s_ready), 32'(rst && q.size() != DEPTH));
        if (known) begin
            chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("m_data", 32'(m_data), 32'(q[0]));
            chk("count", 32'(count), 32'(q.size()));
            chk("almost_full", 32'(almost_full), 32'(q.size() >= AF_LEVEL));
            chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        end
        @(posedge clk);
        if (!rst) begin
            q.delete();
            m_ovf = 1'b0;
            known = 1'b1;
        end else begin
            push = sv && (q.size() != DEPTH);
            pop  = mr && (q.size() != 0);
            if (sv && q.size() == DEPTH) m_ovf = 1'b1;
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(sd);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        m_ovf = 1'b0; known = 1'b0;
        @(negedge clk);

        // reset, then a single word
        repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, 8'hab, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);

        // fill, overflow attempt, drain
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0);
        cyc(1'b1, 1'b1, 8'h55, 1'b0);
        cyc(1'b1, 1'b1, 8'h66, 1'b1);
        repeat (4) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);

        // simultaneous push/pop at count 2
        cyc(1'b1, 1'b1, 8'ha1, 1'b0);
        cyc(1'b1, 1'b1, 8'ha2, 1'b0);
        cyc(1'b1, 1'b1, 8'hc5, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b1);

        // pointer wrap streaming
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 8'(8'h10 + i), 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);

        // reset mid-operation
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'(8'h30 + i), 1'b0);
        cyc(1'b0, 1'b1, 8'h77, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 1'b1, 8'h99, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 8'h00, 1'b1);

        // random traffic
        for (int i = 0; i < 600; i++)
            cyc(($urandom_range(0, 79) != 0), ($urandom_range(0, 2) != 0),
                8'($urandom), ($urandom_range(0, 2) != 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
